// File: rtl/braille_scroll_ctrl.sv
// Message buffer and digit sequencer for a 4-digit Braille display: debounced keys edit or scroll the message.
// Optional macro BRAILLE_SCROLL_LOOP_EN: scroll wraps forever instead of a single pass back to EDIT.
module braille_scroll_ctrl #(
    parameter int DEPTH    = 16,
    parameter int DBNC_CYC = 500_000,
    parameter int TICK_DIV = 25_000_000
) (
    input  logic                           CLOCK_50,
    input  logic                           RESET_N,
    input  logic [4:0]                     SW,
    input  logic [3:0]                     KEY,
    output logic [4:0]                     CODE0,
    output logic [4:0]                     CODE1,
    output logic [4:0]                     CODE2,
    output logic [4:0]                     CODE3,
    output logic [$clog2(DEPTH+1)-1:0]     LEN,
    output logic                           FULL,
    output logic                           SCROLLING
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int BW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = $clog2(DEPTH + 4);
    localparam int CW = $clog2(DBNC_CYC + 1);
    localparam int TW = $clog2(TICK_DIV + 1);

    typedef enum logic {EDIT, SCROLL} state_t;

    logic [3:0]    sync1, sync2, dbnc, press;
    logic [CW-1:0] dcnt [4];

    // press pulses fire on the debounced 1->0 transition only
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            sync1 <= '1;
            sync2 <= '1;
            dbnc  <= '1;
            press <= '0;
            for (int i = 0; i < 4; i++) dcnt[i] <= '0;
        end else begin
            sync1 <= KEY;
            sync2 <= sync1;
            for (int i = 0; i < 4; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == dbnc[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == CW'(DBNC_CYC - 1)) begin
                    dbnc[i]  <= sync2[i];
                    dcnt[i]  <= '0;
                    press[i] <= dbnc[i];
                end else begin
                    dcnt[i] <= dcnt[i] + 1'b1;
                end
            end
        end
    end

    state_t        state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [PW-1:0] pos_q, pos_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          wr_en;
    logic [4:0]    mem [DEPTH];

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        pos_d   = pos_q;
        tcnt_d  = tcnt_q;
        wr_en   = 1'b0;
        if (press[3]) begin
            state_d = EDIT;
            len_d   = '0;
            pos_d   = '0;
            tcnt_d  = '0;
        end else begin
            case (state_q)
                EDIT: begin
                    if (press[2]) begin
                        if (len_q != '0) begin
                            state_d = SCROLL;
                            pos_d   = '0;
                            tcnt_d  = '0;
                        end
                    end else if (press[1]) begin
                        if (len_q != '0) len_d = len_q - 1'b1;
                    end else if (press[0]) begin
                        if (SW <= 5'd26 && len_q < LW'(DEPTH)) begin
                            wr_en = 1'b1;
                            len_d = len_q + 1'b1;
                        end
                    end
                end
                SCROLL: begin
                    if (press[2]) begin
                        state_d = EDIT;
                        pos_d   = '0;
                        tcnt_d  = '0;
                    end else if (tcnt_q == TW'(TICK_DIV - 1)) begin
                        tcnt_d = '0;
                        if (pos_q == PW'(len_q) + PW'(3)) begin
`ifdef BRAILLE_SCROLL_LOOP_EN
                            pos_d = '0;
`else
                            state_d = EDIT;
                            pos_d   = '0;
`endif
                        end else begin
                            pos_d = pos_q + 1'b1;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
                default: state_d = EDIT;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state_q   <= EDIT;
            len_q     <= '0;
            pos_q     <= '0;
            tcnt_q    <= '0;
            FULL      <= 1'b0;
            SCROLLING <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            pos_q     <= pos_d;
            tcnt_q    <= tcnt_d;
            FULL      <= (len_d == LW'(DEPTH));
            SCROLLING <= (state_d == SCROLL);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (wr_en) mem[len_q[BW-1:0]] <= SW;
    end

    assign LEN = len_q;

    // digit k=0 is HEX0; scroll stream is the message followed by four blanks
    logic [4:0] disp [4];
    int         idx;

    always_comb begin
        idx = 0;
        for (int k = 0; k < 4; k++) begin
            disp[k] = 5'd0;
            if (state_q == SCROLL) begin
                idx = int'(pos_q) + (3 - k);
                if (idx >= int'(len_q) + 4) idx = idx - (int'(len_q) + 4);
                if (idx < int'(len_q)) disp[k] = mem[BW'(idx)];
            end else begin
                idx = int'(len_q) - 1 - k;
                if (idx >= 0) disp[k] = mem[BW'(idx)];
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            CODE0 <= '0;
            CODE1 <= '0;
            CODE2 <= '0;
            CODE3 <= '0;
        end else begin
            CODE0 <= disp[0];
            CODE1 <= disp[1];
            CODE2 <= disp[2];
            CODE3 <= disp[3];
        end
    end
endmodule

// File: tb/tb_braille_scroll_ctrl.sv
// Scoreboard bench for braille_scroll_ctrl with short debounce and tick periods.
module tb_braille_scroll_ctrl;
    localparam int DEPTH    = 4;
    localparam int DBNC_CYC = 4;
    localparam int TICK_DIV = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] sw;
    logic [3:0] key;
    logic [4:0] code0, code1, code2, code3;
    logic [2:0] len;
    logic       full, scrolling;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        string tag;
        int    c0, c1, c2, c3, len, full, scr;
    } exp_t;

    exp_t sb[$];
    int   mq[$];

    braille_scroll_ctrl #(.DEPTH(DEPTH), .DBNC_CYC(DBNC_CYC), .TICK_DIV(TICK_DIV)) dut (
        .CLOCK_50(clk), .RESET_N(rst_n), .SW(sw), .KEY(key),
        .CODE0(code0), .CODE1(code1), .CODE2(code2), .CODE3(code3),
        .LEN(len), .FULL(full), .SCROLLING(scrolling)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t exp_edit(input string tag);
        exp_t e;
        int   n;
        n = mq.size();
        e.tag  = tag;
        e.c0   = (n >= 1) ? mq[n-1] : 0;
        e.c1   = (n >= 2) ? mq[n-2] : 0;
        e.c2   = (n >= 3) ? mq[n-3] : 0;
        e.c3   = (n >= 4) ? mq[n-4] : 0;
        e.len  = n;
        e.full = (n == DEPTH) ? 1 : 0;
        e.scr  = 0;
        return e;
    endfunction

    function automatic exp_t exp_scroll(input string tag, input int p);
        exp_t e;
        int   s[$];
        int   m;
        s = mq;
        for (int i = 0; i < 4; i++) s.push_back(0);
        m = s.size();
        e.tag  = tag;
        e.c3   = s[p % m];
        e.c2   = s[(p + 1) % m];
        e.c1   = s[(p + 2) % m];
        e.c0   = s[(p + 3) % m];
        e.len  = mq.size();
        e.full = (mq.size() == DEPTH) ? 1 : 0;
        e.scr  = 1;
        return e;
    endfunction

    task automatic compare_next();
        exp_t e;
        if (sb.size() == 0) begin
            check_val("scoreboard_empty", 0, 1);
            return;
        end
        e = sb.pop_front();
        check_val({e.tag, "_code0"}, int'(code0), e.c0);
        check_val({e.tag, "_code1"}, int'(code1), e.c1);
        check_val({e.tag, "_code2"}, int'(code2), e.c2);
        check_val({e.tag, "_code3"}, int'(code3), e.c3);
        check_val({e.tag, "_len"},   int'(len),   e.len);
        check_val({e.tag, "_full"},  int'(full),  e.full);
        check_val({e.tag, "_scroll"}, int'(scrolling), e.scr);
    endtask

    task automatic press(input logic [3:0] mask, input int hold);
        key = 4'hF & ~mask;
        repeat (hold) @(posedge clk);
        #1 key = 4'hF;
        repeat (14) @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int code, input string tag);
        sw = code[4:0];
        press(4'b0001, 10);
        if (code <= 26 && mq.size() < DEPTH) mq.push_back(code);
        sb.push_back(exp_edit(tag));
        compare_next();
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0;
        key   = 4'hF;
        sw    = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        sb.push_back(exp_edit("reset"));
        compare_next();
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        do_write(1, "wr1");
        do_write(2, "wr2");
        do_write(3, "wr3");
        do_write(4, "wr4_full");
        do_write(5, "wr5_ignored");

        press(4'b0010, 10);
        void'(mq.pop_back());
        sb.push_back(exp_edit("del_to3"));
        compare_next();
        do_write(27, "wr27_invalid");

        press(4'b1000, 10);
        mq.delete();
        sb.push_back(exp_edit("clear"));
        compare_next();

        sw = 5'd7;
        press(4'b0001, 3);
        sb.push_back(exp_edit("glitch"));
        compare_next();
        press(4'b0010, 10);
        sb.push_back(exp_edit("del_empty"));
        compare_next();

        do_write(5, "wr_a");
        do_write(9, "wr_b");

        key = 4'hB;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (scrolling) seen = 1'b1;
        end
        check_val("scroll_start", int'(seen), 1);
        for (int p = 0; p < 6; p++) begin
            repeat ((p == 0) ? 4 : 8) @(posedge clk);
            #1;
            if (p == 1) key = 4'hF;
            sb.push_back(exp_scroll($sformatf("scroll_p%0d", p), p));
            compare_next();
        end
        repeat (8) @(posedge clk);
        #1;
`ifdef BRAILLE_SCROLL_LOOP_EN
        sb.push_back(exp_scroll("scroll_wrap", 0));
        compare_next();
        press(4'b0100, 10);
        sb.push_back(exp_edit("stop"));
        compare_next();
`else
        sb.push_back(exp_edit("scroll_end"));
        compare_next();
`endif

        sw = 5'd11;
        press(4'b1001, 10);
        mq.delete();
        sb.push_back(exp_edit("clear_vs_write"));
        compare_next();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
